// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: instruction field
// constants, FSM state encoding, branch/jump status codes, ALU select
// encodings and the one-hot instruction class vector layout.
package mc_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned STATE_W  = 4;
   localparam int unsigned STATUS_W = 3;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned SRCB_W   = 2;

   // Primary opcodes
   localparam logic [OP_W-1:0] OP_RFMT  = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BMN   = 6'b010101;
   localparam logic [OP_W-1:0] OP_BZ    = 6'b011000;
   localparam logic [OP_W-1:0] OP_JALM  = 6'b010011;
   localparam logic [OP_W-1:0] OP_JSPAL = 6'b010111;

   // Function codes carved out of the R-format opcode space
   localparam logic [FUNCT_W-1:0] FN_BRZ  = 6'b010100;
   localparam logic [FUNCT_W-1:0] FN_JMOR = 6'b100101;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9
   } state_t;

   // Branch/jump class codes handed to the branch control unit
   localparam logic [STATUS_W-1:0] ST_NONE  = 3'b000;
   localparam logic [STATUS_W-1:0] ST_BMN   = 3'b001;
   localparam logic [STATUS_W-1:0] ST_BRZ   = 3'b010;
   localparam logic [STATUS_W-1:0] ST_BZ    = 3'b011;
   localparam logic [STATUS_W-1:0] ST_JMOR  = 3'b100;
   localparam logic [STATUS_W-1:0] ST_JALM  = 3'b101;
   localparam logic [STATUS_W-1:0] ST_JSPAL = 3'b110;
   localparam logic [STATUS_W-1:0] ST_BEQ   = 3'b111;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

   localparam logic [SRCB_W-1:0] SRCB_RT     = 2'b00;
   localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
   localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
   localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

   // Bit positions in the one-hot class vector; all-zero means undecodable
   localparam int unsigned CL_RFMT  = 0;
   localparam int unsigned CL_LW    = 1;
   localparam int unsigned CL_SW    = 2;
   localparam int unsigned CL_BEQ   = 3;
   localparam int unsigned CL_BMN   = 4;
   localparam int unsigned CL_BZ    = 5;
   localparam int unsigned CL_BRZ   = 6;
   localparam int unsigned CL_JMOR  = 7;
   localparam int unsigned CL_JALM  = 8;
   localparam int unsigned CL_JSPAL = 9;
   localparam int unsigned NUM_CL   = 10;

   typedef logic [NUM_CL-1:0] class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM and its datapath.
//   master : control unit (drives strobes/selects, status, state; reads
//            opcode, funct, mem_ready)
//   slave  : datapath / memory side (the reverse)
interface multicycle_control_if;
   import mc_pkg::*;

   logic [OP_W-1:0]     opcode;
   logic [FUNCT_W-1:0]  funct;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                ir_write;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                mem_to_reg;
   logic                reg_write;
   logic                reg_dest;
   logic                alu_src_a;
   logic [SRCB_W-1:0]   alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic [STATUS_W-1:0] status;
   logic                illegal;
   logic [STATE_W-1:0]  state;

   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_write, reg_dest, alu_src_a, alu_src_b, alu_op,
             status, illegal, state
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_write, reg_dest, alu_src_a, alu_src_b, alu_op,
             status, illegal, state
   );

endinterface

// File: rtl/insn_decode.sv
// Combinational instruction classifier.
//   i_opcode    : instruction bits [31:26]
//   i_funct     : instruction bits [5:0]
//   o_class_c   : one-hot class vector (zero when undecodable)
//   o_status_c  : branch/jump status code for the class
module insn_decode
   import mc_pkg::*;
(
   input  logic [OP_W-1:0]     i_opcode,
   input  logic [FUNCT_W-1:0]  i_funct,
   output class_t              o_class_c,
   output logic [STATUS_W-1:0] o_status_c
);

   // Opcode 0 is R-format unless funct selects brz or jmor
   always_comb begin
      o_class_c  = '0;
      o_status_c = ST_NONE;
      case (i_opcode)
         OP_RFMT: begin
            if (i_funct == FN_BRZ) begin
               o_class_c[CL_BRZ] = 1'b1;
               o_status_c        = ST_BRZ;
            end else if (i_funct == FN_JMOR) begin
               o_class_c[CL_JMOR] = 1'b1;
               o_status_c         = ST_JMOR;
            end else begin
               o_class_c[CL_RFMT] = 1'b1;
            end
         end
         OP_LW:    o_class_c[CL_LW] = 1'b1;
         OP_SW:    o_class_c[CL_SW] = 1'b1;
         OP_BEQ: begin
            o_class_c[CL_BEQ] = 1'b1;
            o_status_c        = ST_BEQ;
         end
         OP_BMN: begin
            o_class_c[CL_BMN] = 1'b1;
            o_status_c        = ST_BMN;
         end
         OP_BZ: begin
            o_class_c[CL_BZ] = 1'b1;
            o_status_c       = ST_BZ;
         end
         OP_JALM: begin
            o_class_c[CL_JALM] = 1'b1;
            o_status_c         = ST_JALM;
         end
         OP_JSPAL: begin
            o_class_c[CL_JSPAL] = 1'b1;
            o_status_c          = ST_JSPAL;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM.
//   clk, reset : clock and synchronous active-high reset
//   bus        : control bus (master side) - opcode/funct/mem_ready in,
//                datapath strobes and selects, latched status and current
//                state out
// Strobes and selects are decoded from the current state (and mem_ready in
// wait states); status and state are registered.
module multicycle_control
   import mc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   multicycle_control_if.master bus
);

   state_t               r_state;
   state_t               w_next_state;
   logic [STATUS_W-1:0]  r_status;
   class_t               w_class;
   logic [STATUS_W-1:0]  w_status_dec;

   logic                 w_pc_write;
   logic                 w_pc_write_cond;
   logic                 w_ir_write;
   logic                 w_i_or_d;
   logic                 w_mem_read;
   logic                 w_mem_write;
   logic                 w_mem_to_reg;
   logic                 w_reg_write;
   logic                 w_reg_dest;
   logic                 w_alu_src_a;
   logic [SRCB_W-1:0]    w_alu_src_b;
   logic [ALUOP_W-1:0]   w_alu_op;
   logic                 w_illegal;

   insn_decode u_insn_decode (
      .i_opcode   (bus.opcode),
      .i_funct    (bus.funct),
      .o_class_c  (w_class),
      .o_status_c (w_status_dec)
   );

   // State register; status is captured as DECODE is left
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_status <= ST_NONE;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) begin
            r_status <= w_status_dec;
         end
      end
   end

   // Next state and per-state control outputs
   always_comb begin
      w_next_state    = S_FETCH;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_ir_write      = 1'b0;
      w_i_or_d        = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_reg_write     = 1'b0;
      w_reg_dest      = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = SRCB_RT;
      w_alu_op        = ALU_ADD;
      w_illegal       = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            if (bus.mem_ready) begin
               w_ir_write   = 1'b1;
               w_pc_write   = 1'b1;
               w_next_state = S_DECODE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_DECODE: begin
            w_alu_src_b = SRCB_IMM_SH;
            if (w_class[CL_LW] || w_class[CL_SW]) begin
               w_next_state = S_MEM_ADDR;
            end else if (w_class[CL_RFMT]) begin
               w_next_state = S_R_EXEC;
            end else if (w_class[CL_BEQ] || w_class[CL_BZ] ||
                         w_class[CL_BMN] || w_class[CL_BRZ]) begin
               w_next_state = S_BRANCH;
            end else if (w_class[CL_JMOR] || w_class[CL_JALM] ||
                         w_class[CL_JSPAL]) begin
               w_next_state = S_JUMP;
            end else begin
               w_illegal    = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_IMM;
            w_next_state = w_class[CL_LW] ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            w_mem_read   = 1'b1;
            w_i_or_d     = 1'b1;
            w_next_state = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEM_WR: begin
            w_mem_write  = 1'b1;
            w_i_or_d     = 1'b1;
            w_next_state = bus.mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_R_EXEC: begin
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_RT;
            w_alu_op     = ALU_FUNCT;
            w_next_state = S_R_WB;
         end
         S_R_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dest   = 1'b1;
            w_next_state = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_SUB;
            // bmn compares against a memory operand, so it waits on memory
            if (r_status == ST_BMN) begin
               w_mem_read = 1'b1;
               w_i_or_d   = 1'b1;
               if (bus.mem_ready) begin
                  w_pc_write_cond = 1'b1;
                  w_next_state    = S_FETCH;
               end else begin
                  w_next_state = S_BRANCH;
               end
            end else begin
               w_pc_write_cond = 1'b1;
               w_next_state    = S_FETCH;
            end
         end
         S_JUMP: begin
            // jalm fetches its target from memory; strobes wait for it
            if (r_status == ST_JALM) begin
               w_mem_read = 1'b1;
               w_i_or_d   = 1'b1;
               if (bus.mem_ready) begin
                  w_pc_write_cond = 1'b1;
                  w_reg_write     = 1'b1;
                  w_next_state    = S_FETCH;
               end else begin
                  w_next_state = S_JUMP;
               end
            end else begin
               w_pc_write_cond = 1'b1;
               w_reg_write     = (r_status == ST_JSPAL);
               w_next_state    = S_FETCH;
            end
         end
         default: w_next_state = S_FETCH;
      endcase

      // Reset cycle: no strobe may reach the datapath or memory
      if (reset) begin
         w_pc_write      = 1'b0;
         w_pc_write_cond = 1'b0;
         w_ir_write      = 1'b0;
         w_mem_read      = 1'b0;
         w_mem_write     = 1'b0;
         w_reg_write     = 1'b0;
         w_illegal       = 1'b0;
      end
   end

   assign bus.pc_write      = w_pc_write;
   assign bus.pc_write_cond = w_pc_write_cond;
   assign bus.ir_write      = w_ir_write;
   assign bus.i_or_d        = w_i_or_d;
   assign bus.mem_read      = w_mem_read;
   assign bus.mem_write     = w_mem_write;
   assign bus.mem_to_reg    = w_mem_to_reg;
   assign bus.reg_write     = w_reg_write;
   assign bus.reg_dest      = w_reg_dest;
   assign bus.alu_src_a     = w_alu_src_a;
   assign bus.alu_src_b     = w_alu_src_b;
   assign bus.alu_op        = w_alu_op;
   assign bus.illegal       = w_illegal;
   assign bus.status        = r_status;
   assign bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instructions, a randomized
// instruction stream with random memory wait counts, and reset-abort cases.
// Expected per-cycle traces are built from the instruction-level sequence
// of each class.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Control word layout:
   // {illegal, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
   //  reg_write, mem_to_reg, reg_dest, i_or_d, alu_src_a, alu_src_b, alu_op}
   localparam logic [14:0] ILL    = 15'h4000;
   localparam logic [14:0] PCW    = 15'h2000;
   localparam logic [14:0] PCC    = 15'h1000;
   localparam logic [14:0] IRW    = 15'h0800;
   localparam logic [14:0] MRD    = 15'h0400;
   localparam logic [14:0] MWR    = 15'h0200;
   localparam logic [14:0] RW     = 15'h0100;
   localparam logic [14:0] M2R    = 15'h0080;
   localparam logic [14:0] RD     = 15'h0040;
   localparam logic [14:0] IOD    = 15'h0020;
   localparam logic [14:0] ASA    = 15'h0010;
   localparam logic [14:0] B_4    = 15'h0004;
   localparam logic [14:0] B_IMM  = 15'h0008;
   localparam logic [14:0] B_SH   = 15'h000C;
   localparam logic [14:0] OP_SUB = 15'h0001;
   localparam logic [14:0] OP_F   = 15'h0002;

   typedef enum int {K_RFMT, K_LW, K_SW, K_BEQ, K_BMN, K_BZ, K_BRZ,
                     K_JMOR, K_JALM, K_JSPAL, K_ILL} kind_t;

   typedef struct {
      int          st;
      logic        mr;
      logic [14:0] ctl;
      logic [2:0]  stat;
   } cyc_t;

   cyc_t       q[$];
   logic [2:0] m_status;
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc_no   = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return (fn == 6'b010100) ? K_BRZ :
                           (fn == 6'b100101) ? K_JMOR : K_RFMT;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b010101: return K_BMN;
         6'b011000: return K_BZ;
         6'b010011: return K_JALM;
         6'b010111: return K_JSPAL;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] status_of(input kind_t k);
      case (k)
         K_BEQ:   return 3'b111;
         K_BMN:   return 3'b001;
         K_BZ:    return 3'b011;
         K_BRZ:   return 3'b010;
         K_JMOR:  return 3'b100;
         K_JALM:  return 3'b101;
         K_JSPAL: return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [14:0] observed();
      return {bus.illegal, bus.pc_write, bus.pc_write_cond, bus.ir_write,
              bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg,
              bus.reg_dest, bus.i_or_d, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op};
   endfunction

   task automatic add(input int st, input logic mr, input logic [14:0] c);
      cyc_t r;
      r.st   = st;
      r.mr   = mr;
      r.ctl  = c;
      r.stat = m_status;
      q.push_back(r);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Memory phase: w not-ready cycles, then the completing cycle
   task automatic add_wait(input int st, input int w, input logic [14:0] c_wait,
                           input logic [14:0] c_done);
      for (int i = 0; i < w; i++) add(st, 1'b0, c_wait);
      add(st, 1'b1, c_done);
   endtask

   task automatic check_cycle(input string tag, input int st,
                              input logic [14:0] c, input logic [2:0] s);
      check($sformatf("%s state c%0d", tag, cyc_no), 32'(bus.state), 32'(st));
      check($sformatf("%s ctrl c%0d", tag, cyc_no), 32'(observed()), 32'(c));
      check($sformatf("%s status c%0d", tag, cyc_no), 32'(bus.status), 32'(s));
   endtask

   // Build the expected trace of one instruction, then drive and compare it
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int forced_wait);
      kind_t k;
      int    w;
      k = classify(op, fn);
      q.delete();
      w = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
      add_wait(0, w, MRD | B_4, MRD | B_4 | IRW | PCW);
      add(1, rnd_bit(), B_SH | ((k == K_ILL) ? ILL : 15'h0));
      m_status = status_of(k);
      w = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
      case (k)
         K_LW: begin
            add(2, rnd_bit(), ASA | B_IMM);
            add_wait(3, w, MRD | IOD, MRD | IOD);
            add(4, rnd_bit(), RW | M2R);
         end
         K_SW: begin
            add(2, rnd_bit(), ASA | B_IMM);
            add_wait(5, w, MWR | IOD, MWR | IOD);
         end
         K_RFMT: begin
            add(6, rnd_bit(), ASA | OP_F);
            add(7, rnd_bit(), RW | RD);
         end
         K_BEQ, K_BZ, K_BRZ: add(8, rnd_bit(), ASA | OP_SUB | PCC);
         K_BMN: add_wait(8, w, ASA | OP_SUB | MRD | IOD,
                         ASA | OP_SUB | MRD | IOD | PCC);
         K_JMOR:  add(9, rnd_bit(), PCC);
         K_JSPAL: add(9, rnd_bit(), PCC | RW);
         K_JALM:  add_wait(9, w, MRD | IOD, MRD | IOD | PCC | RW);
         default: ;
      endcase
      foreach (q[i]) begin
         @(negedge clk);
         if (i == 0) begin
            bus.opcode = op;
            bus.funct  = fn;
         end
         bus.mem_ready = q[i].mr;
         #1;
         cyc_no++;
         check_cycle(k.name(), q[i].st, q[i].ctl, q[i].stat);
      end
   endtask

   task automatic pick_random(output logic [5:0] op, output logic [5:0] fn);
      kind_t k;
      k  = kind_t'($urandom_range(0, 10));
      fn = 6'($urandom);
      case (k)
         K_RFMT: begin
            op = 6'b000000;
            while (fn == 6'b010100 || fn == 6'b100101) fn = 6'($urandom);
         end
         K_BRZ:   begin op = 6'b000000; fn = 6'b010100; end
         K_JMOR:  begin op = 6'b000000; fn = 6'b100101; end
         K_LW:    op = 6'b100011;
         K_SW:    op = 6'b101011;
         K_BEQ:   op = 6'b000100;
         K_BMN:   op = 6'b010101;
         K_BZ:    op = 6'b011000;
         K_JALM:  op = 6'b010011;
         K_JSPAL: op = 6'b010111;
         default: begin
            op = 6'($urandom);
            while (classify(op, fn) != K_ILL) op = 6'($urandom);
         end
      endcase
   endtask

   // Drive one free-running cycle and compare
   task automatic step(input string tag, input logic mr, input int st,
                       input logic [14:0] c, input logic [2:0] s);
      @(negedge clk);
      bus.mem_ready = mr;
      #1;
      cyc_no++;
      check_cycle(tag, st, c, s);
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] fn;

      reset         = 1'b1;
      bus.opcode    = 6'b0;
      bus.funct     = 6'b0;
      bus.mem_ready = 1'b0;
      m_status      = 3'b000;
      repeat (2) @(negedge clk);
      #1;
      check_cycle("reset", 0, B_4, 3'b000);
      reset = 1'b0;

      // Directed cases
      run_instr(6'b100011, 6'b000000, 0);   // lw, no waits
      run_instr(6'b101011, 6'b000000, 3);   // sw, 3 wait cycles
      run_instr(6'b010101, 6'b000000, 2);   // bmn
      run_instr(6'b111111, 6'b000000, 0);   // illegal
      run_instr(6'b000000, 6'b100101, 1);   // jmor
      run_instr(6'b000000, 6'b100000, 0);   // add
      run_instr(6'b010011, 6'b000000, 2);   // jalm
      run_instr(6'b010111, 6'b000000, 0);   // jspal
      run_instr(6'b000100, 6'b000000, 0);   // beq
      run_instr(6'b000000, 6'b010100, 0);   // brz

      // Random instruction stream
      for (int n = 0; n < 150; n++) begin
         pick_random(op, fn);
         run_instr(op, fn, -1);
      end

      // Reset while a lw read is waiting: access abandoned, no writeback
      @(negedge clk);
      bus.opcode = 6'b100011;
      bus.funct  = 6'b0;
      bus.mem_ready = 1'b1;
      #1;
      check_cycle("rst_lw", 0, MRD | B_4 | IRW | PCW, m_status);
      step("rst_lw", 1'b1, 1, B_SH, m_status);
      m_status = 3'b000;
      step("rst_lw", 1'b1, 2, ASA | B_IMM, m_status);
      step("rst_lw", 1'b0, 3, MRD | IOD, m_status);
      reset = 1'b1;
      #1;
      check("rst_lw strobes off", 32'(observed()), 32'(IOD));
      step("rst_lw", 1'b0, 0, B_4, 3'b000);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step("rst_lw idle", 1'b0, 0, MRD | B_4, 3'b000);

      // Reset while bmn waits on memory: status cleared, no PC strobe
      @(negedge clk);
      bus.opcode = 6'b010101;
      bus.mem_ready = 1'b1;
      #1;
      check_cycle("rst_bmn", 0, MRD | B_4 | IRW | PCW, 3'b000);
      step("rst_bmn", 1'b1, 1, B_SH, 3'b000);
      step("rst_bmn", 1'b0, 8, ASA | OP_SUB | MRD | IOD, 3'b001);
      reset = 1'b1;
      #1;
      check("rst_bmn strobes off", 32'(observed()), 32'(ASA | OP_SUB | IOD));
      step("rst_bmn", 1'b0, 0, B_4, 3'b000);
      reset = 1'b0;
      bus.mem_ready = 1'b0;
      m_status = 3'b000;

      // Recovery after reset
      run_instr(6'b000000, 6'b100010, -1);
      run_instr(6'b100011, 6'b000000, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  6  instruction bits [31:26], valid from DECODE onward.
REQ-004 funct  input  6  instruction bits [5:0], valid from DECODE onward.
REQ-005 mem_ready  input  1  memory handshake; current read/write completes in a cycle where mem_ready=1.
REQ-006 pc_write  output  1  unconditional PC load strobe.
REQ-007 pc_write_cond  output  1  PC load qualified by the branch control unit using status.
REQ-008 ir_write  output  1  instruction register load strobe.
REQ-009 i_or_d  output  1  memory address select: 0=PC, 1=ALU out.
REQ-010 mem_read, mem_write  output  1 each  memory request strobes.
REQ-011 mem_to_reg, reg_write, reg_dest  output  1 each  register file writeback controls.
REQ-012 alu_src_a  output  1  0=PC, 1=rs; alu_src_b  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-013 alu_op  output  2  00=add, 01=sub, 10=funct-decoded.
REQ-014 status  output  3  registered branch/jump class code for the branch control unit.
REQ-015 illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-016 state  output  4  current FSM state, for debug and bench.

Function
REQ-017 Classes: rformat=op 000000 (except brz, jmor); lw=100011; sw=101011; beq=000100; bmn=010101; bz=011000; jalm=010011; jspal=010111; brz=op 0, funct 010100; jmor=op 0, funct 100101.
REQ-018 status codes: beq=111, bmn=001, bz=011, brz=010, jmor=100, jalm=101, jspal=110, all others 000; latched at DECODE exit, held until the next DECODE.
REQ-019 States/encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9; codes 10-15 go to FETCH on the next edge.
REQ-020 Every output not listed for a state is 0.
REQ-021 FETCH: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00; stays while mem_ready=0; when mem_ready=1, ir_write=1 and pc_write=1 in that cycle, then DECODE.
REQ-022 DECODE: alu_src_b=11, alu_op=00; next state lw/sw->MEM_ADDR, rformat->R_EXEC, beq/bz/bmn/brz->BRANCH, jmor/jalm/jspal->JUMP, otherwise illegal=1 for this cycle, then FETCH.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD for lw, MEM_WR for sw.
REQ-024 MEM_RD: mem_read=1, i_or_d=1; waits for mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0; then FETCH.
REQ-025 MEM_WR: mem_write=1, i_or_d=1; waits for mem_ready, then FETCH.
REQ-026 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB. R_WB: reg_write=1, reg_dest=1; then FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_op=01. For bmn: mem_read=1 and i_or_d=1; waits for mem_ready; pc_write_cond=1 only in the mem_ready cycle. For other branches: pc_write_cond=1 for one cycle. Then FETCH.
REQ-028 JUMP: pc_write_cond=1. For jalm: mem_read=1 and i_or_d=1; waits for mem_ready; strobes only in the completing cycle. For jalm/jspal: reg_write=1 (link) in the completing cycle. Then FETCH.
REQ-029 Every instruction ends in FETCH. Minimum latency with mem_ready tied to 1: lw 5, sw 4, rformat 4, branch/jump 3 cycles.
REQ-030 mem_read and mem_write are never both 1. pc_write and pc_write_cond are never both 1.

Reset
REQ-031 While reset=1: on the next edge state<=FETCH and status<=000; in the reset cycle all strobe outputs (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal) are forced to 0.
REQ-032 Reset during a memory wait abandons the access; no writeback or PC strobe occurs for that access.

Structure
REQ-033 Shared package mc_pkg holds the opcode/funct constants, the state enum, the status codes, and the alu_op/alu_src_b encodings.
REQ-034 One combinational sub-module, insn_decode, maps opcode/funct to a one-hot class vector plus the status code; the FSM lives in multicycle_control.

Verification
REQ-035 lw (op 100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4 only.
REQ-036 sw, mem_ready low for 3 cycles in MEM_WR -> mem_write=1 held for 4 cycles, no reg_write, then FETCH.
REQ-037 bmn (op 010101) -> status=001 from the cycle after DECODE; pc_write_cond=1 exactly in the mem_ready cycle.
REQ-038 op 111111 -> illegal=1 for one cycle in DECODE, state returns to 0, no other strobes.
REQ-039 reset=1 asserted in MEM_RD while mem_ready=0 -> state=0 and status=000 next cycle; reg_write never asserted.
REQ-040 op 0 / funct 100101 (jmor) -> status=100, JUMP with pc_write_cond=1, reg_write=0; add (funct 100000) -> R_EXEC with alu_op=10.
